// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit.
//   mem_access_type : memory-access kind produced by instruction decode
//   lsu_fault_t     : fault cause reported with a response
//   lsu_state_e     : load_store_unit FSM states
//   mem_cmd_t       : command payload held on the data-memory bus while requesting
package load_store_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = 2;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_access_type;

    typedef enum logic [1:0] {
        LSU_FAULT_NONE     = 2'd0,
        LSU_FAULT_MISALIGN = 2'd1,
        LSU_FAULT_TIMEOUT  = 2'd2
    } lsu_fault_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // True for the three store flavours.
    function automatic logic is_store(mem_access_type t);
        return (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid bus.
//   master (LSU)    : drives mem_req, mem_addr, mem_we, mem_be, mem_wdata
//   slave  (memory) : drives mem_gnt, mem_rvalid, mem_rdata
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
//   access_type_i : access kind
//   off_i         : byte offset addr[1:0]
//   wdata_i       : store data (rs2)
//   rdata_i       : word returned by memory
//   be_c          : byte enables
//   wdata_c       : lane-replicated store data
//   rdata_c       : extracted, sign/zero-extended load data (0 for non-loads)
//   misaligned_c  : access must trap (only with LSU_MISALIGN_TRAP_EN defined)
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  mem_access_type   access_type_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [BE_W-1:0]  be_c,
    output logic [XLEN-1:0]  wdata_c,
    output logic [XLEN-1:0]  rdata_c,
    output logic             misaligned_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Halfwords select on addr[1] only; a set addr[0] is either trapped or ignored.
    assign byte_c = rdata_i[{off_i, 3'b000} +: 8];
    assign half_c = rdata_i[{off_i[1], 4'b0000} +: 16];

    // Lane steering and load extension.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_i;
        rdata_c = '0;
        case (access_type_i)
            MEM_LB:  rdata_c = {{24{byte_c[7]}}, byte_c};
            MEM_LBU: rdata_c = {24'h0, byte_c};
            MEM_LH:  rdata_c = {{16{half_c[15]}}, half_c};
            MEM_LHU: rdata_c = {16'h0, half_c};
            MEM_LW:  rdata_c = rdata_i;
            MEM_SB: begin
                be_c    = 4'b0001 << off_i;
                wdata_c = {4{wdata_i[7:0]}};
            end
            MEM_SH: begin
                be_c    = 4'b0011 << {off_i[1], 1'b0};
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Misalignment detection.
    always_comb begin
        misaligned_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (access_type_i)
            MEM_LH, MEM_LHU, MEM_SH: misaligned_c = off_i[0];
            MEM_LW, MEM_SW:          misaligned_c = (off_i != 2'b00);
            default: ;
        endcase
`else
        misaligned_c = 1'b0;
`endif
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one load or store per pipeline request over a req/gnt/rvalid bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned halfword/word accesses).
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid/ready  : pipeline request handshake
//   access_type      : decoded memory-access kind
//   addr, wdata      : byte address, store data (rs2)
//   resp_valid       : one-cycle result/fault pulse
//   resp_data        : extended load data, 0 for stores/NONE/faults
//   fault/fault_cause: fault flag and cause
//   mem              : data-memory bus (master side)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  mem_access_type         access_type,
    input  logic [XLEN-1:0]        addr,
    input  logic [XLEN-1:0]        wdata,
    output logic                   resp_valid,
    output logic [XLEN-1:0]        resp_data,
    output logic                   fault,
    output lsu_fault_t             fault_cause,
    load_store_unit_if.master      mem
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e       state_q, state_d;
    mem_access_type   type_q, type_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             mem_req_q, mem_req_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic             fault_q, fault_d;
    lsu_fault_t       cause_q, cause_d;

    mem_access_type   lane_type_c;
    logic [OFF_W-1:0] lane_off_c;
    logic [BE_W-1:0]  lane_be_c;
    logic [XLEN-1:0]  lane_wdata_c;
    logic [XLEN-1:0]  lane_rdata_c;
    logic             lane_mis_c;
    logic             timeout_hit_c;

    // Lane logic sees the live request while idle, the latched one afterwards.
    assign lane_type_c = (state_q == ST_IDLE) ? access_type : type_q;
    assign lane_off_c  = (state_q == ST_IDLE) ? addr[1:0]   : off_q;

    lsu_lane_align u_lane (
        .access_type_i (lane_type_c),
        .off_i         (lane_off_c),
        .wdata_i       (wdata),
        .rdata_i       (mem.mem_rdata),
        .be_c          (lane_be_c),
        .wdata_c       (lane_wdata_c),
        .rdata_c       (lane_rdata_c),
        .misaligned_c  (lane_mis_c)
    );

    // Counter reaches TIMEOUT_CYCLES-1 on the last allowed REQ/WAIT cycle.
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                           (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        mem_req_d    = 1'b0;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        fault_d      = 1'b0;
        cause_d      = LSU_FAULT_NONE;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    type_d = access_type;
                    off_d  = addr[1:0];
                    if ((access_type == MEM_NONE) || lane_mis_c) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        fault_d      = lane_mis_c;
                        cause_d      = lane_mis_c ? LSU_FAULT_MISALIGN : LSU_FAULT_NONE;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        cnt_d       = '0;
                        cmd_d.addr  = {addr[XLEN-1:2], 2'b00};
                        cmd_d.we    = is_store(access_type);
                        cmd_d.be    = lane_be_c;
                        cmd_d.wdata = lane_wdata_c;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A timeout beats a grant arriving in the same cycle.
                if (timeout_hit_c) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b1;
                    cause_d      = LSU_FAULT_TIMEOUT;
                end else if (mem.mem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the last allowed cycle still completes normally.
                if (mem.mem_rvalid) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = lane_rdata_c;
                end else if (timeout_hit_c) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b1;
                    cause_d      = LSU_FAULT_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            type_q       <= MEM_NONE;
            off_q        <= '0;
            cnt_q        <= '0;
            cmd_q        <= '0;
            mem_req_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            fault_q      <= 1'b0;
            cause_q      <= LSU_FAULT_NONE;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            mem_req_q    <= mem_req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = cmd_q.addr;
    assign mem.mem_we    = cmd_q.we;
    assign mem.mem_be    = cmd_q.be;
    assign mem.mem_wdata = cmd_q.wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumes the memory-access type produced by instruction decode, plus the ALU-computed address and the rs2 store data.
- Executes exactly one load or store per request over a simple req/gnt/rvalid data-memory bus.
- Performs byte-lane steering for stores, and extraction plus sign/zero extension for loads.
- Returns a writeback result or a fault to the pipeline. Sits between execute and writeback.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before a bus-timeout fault. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  pipeline request valid
- req_ready  out  1  LSU can accept a request
- access_type  in  4  common::mem_access_type (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW)
- addr  in  32  byte address
- wdata  in  32  store data (rs2)
- resp_valid  out  1  result/fault valid, one-cycle pulse
- resp_data  out  32  extended load data; 0 for stores, NONE and faults
- fault  out  1  access faulted
- fault_cause  out  2  common::lsu_fault_t
- mem_req  out  1  bus request
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_we  out  1  1 = store
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  bus response (both loads and stores)
- mem_rdata  in  32  load word

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_data=0; fault=0; fault_cause=NONE; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; timeout counter=0.
- Assertion of rst_n low in any state aborts the operation immediately. No response is produced for the aborted request.
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - req_ready=1 only here.
  - On req_valid: latch access_type, addr and wdata.
  - If access_type is NONE, or the access is misaligned-trapped: go to DONE, no bus activity.
  - Otherwise go to REQ.
- REQ
  - mem_req=1, with mem_addr/we/be/wdata held stable until mem_gnt.
  - On mem_gnt: go to WAIT; mem_req drops the next cycle.
  - mem_rvalid is ignored in REQ.
- WAIT
  - mem_req=0.
  - On mem_rvalid: capture mem_rdata and go to DONE.
- DONE
  - resp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency: accept at cycle 0; mem_req at 1; gnt at 1; rvalid at 2; resp_valid at 3. NONE responds at cycle 1.
- Timeout
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: drop mem_req, go to DONE with fault=1, fault_cause=TIMEOUT.
  - A late mem_rvalid seen in IDLE or DONE is ignored.
- Lane rules (off=addr[1:0])
  - SB: be=4'b0001<<off; wdata byte replicated x4.
  - SH: be=4'b0011<<{off[1],1'b0}; halfword replicated x2.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, we=0.
- Load extraction
  - LB/LBU: rdata[8*off+:8], sign/zero-extended.
  - LH/LHU: rdata[16*off[1]+:16], sign/zero-extended.
  - LW: full word.
- Stores respond with resp_data=0.
- Only one outstanding transaction exists; no new acceptance until DONE has completed.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1 → misaligned.
  - LW/SW with addr[1:0]!=0 → misaligned.
  - A misaligned access makes no bus access and goes IDLE→DONE with fault=1, fault_cause=MISALIGN, resp_data=0.
- Undefined:
  - No misalign check.
  - Halfwords use addr[1] only; words ignore addr[1:0].
  - fault_cause is never MISALIGN.

Decomposition:
- Package common gains lsu_fault_t as a 2-bit enum: NONE=0, MISALIGN=1, TIMEOUT=2.
- common::mem_access_type is reused unchanged.
- Sub-module lsu_lane_align (combinational):
  - inputs access_type, addr[1:0], wdata, rdata;
  - outputs be, steered wdata, extended rdata, misaligned flag.
- FSM and timeout counter live in load_store_unit.

Test Plan:
- LW at addr 0x100; gnt at cycle 1; rvalid at cycle 2 with rdata 0xDEADBEEF → mem_addr=0x100, be=4'b1111, resp_valid at cycle 3, resp_data=0xDEADBEEF, fault=0.
- LB at addr 0x103, rdata 0x80FF_0000 → resp_data=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at addr 0x202, wdata 0x1234ABCD → mem_addr=0x200, be=4'b1100, mem_wdata=0xABCDABCD, we=1; after rvalid, resp_data=0.
- LW at 0x300 with mem_gnt withheld for 3 cycles → mem_req and its address held stable for 4 cycles; the request completes normally after gnt.
- TIMEOUT_CYCLES=16, gnt arrives but rvalid never does → resp_valid with fault=1, cause=TIMEOUT, 16 cycles after REQ entry; rvalid injected later is ignored; next request is accepted normally.
- With LSU_MISALIGN_TRAP_EN: SW at 0x401 → no mem_req, resp_valid at cycle 1, fault_cause=MISALIGN.
- Without LSU_MISALIGN_TRAP_EN: SW at 0x401 → bus store at 0x400 with be=4'b1111, no fault.
- Reset asserted during WAIT → all outputs return to reset values; no resp_valid is produced.
